// File: rtl/kl_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package     : kl_pipe_pkg
// Description : Shared definitions for the pipeline scoreboard. Holds the
//               register-file geometry defaults, the register-index type, the
//               scoreboard control states and the pipeline opcode constants.
// Revision    : 1.0 - initial release
// ============================================================================
package kl_pipe_pkg;

  localparam int KL_NREGS = 8;
  localparam int KL_CNT_W = 2;
  localparam int KL_IDX_W = $clog2(KL_NREGS);

  typedef logic [KL_IDX_W-1:0] reg_idx_t;

  // Scoreboard control states
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } sb_state_e;

  // Pipeline opcodes
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_LDR = 3'b011;
  localparam logic [2:0] OP_STR = 3'b100;
  localparam logic [2:0] OP_BR  = 3'b101;

  // Largest value an in-flight counter of the given width can hold
  function automatic int cnt_max(input int width);
    return (1 << width) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sb_counter.sv
`default_nettype none
// ============================================================================
// Module      : sb_counter
// Description : One saturating up/down in-flight write counter for a single
//               architectural register, with an underflow indication.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               inc_i          - one more write issued to this register
//               dec_i          - one write retired at writeback
//               cnt_o          - current count
//               sat_o          - count is at its maximum
//               next_zero_o    - count will be zero after this edge
//               uflow_o        - writeback arrived while count was zero
// Revision    : 1.0 - initial release
// ============================================================================
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o,
  output logic             next_zero_o,
  output logic             uflow_o
);

  localparam logic [CNT_W-1:0] C_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_ZERO = '0;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Simultaneous inc and dec cancel. Both ends clamp so the count never wraps;
  // the issue side relies on sat_o to keep inc away from a full counter.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != C_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && (cnt_q != C_ZERO)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= C_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign sat_o       = (cnt_q == C_MAX);
  assign next_zero_o = (cnt_d == C_ZERO);
  assign uflow_o     = dec_i && (cnt_q == C_ZERO);

endmodule
`default_nettype wire

// File: rtl/pipeline_scoreboard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_scoreboard_ctrl
// Description : Register scoreboard for an in-order pipeline. Tracks the
//               number of in-flight writes per register, stalls decode on
//               source hazards or counter saturation, and provides a
//               drain/halt handshake for quiescing the pipeline.
// Ports       : clk, rst                  - clock, synchronous active-high reset
//               issue_valid_i             - decode presents an instruction
//               issue_rs_a_i/issue_rs_b_i - source registers
//               issue_use_a_i/issue_use_b_i - source actually read
//               issue_write_i/issue_rd_i  - instruction writes issue_rd_i
//               wb_write_i/wb_writenum_i  - writeback to wb_writenum_i
//               drain_req_i               - level request to quiesce
//               stall_o                   - decode must hold (combinational)
//               issue_fire_o              - instruction issues (combinational)
//               busy_mask_o               - per-register nonzero count
//               halted_o                  - drained, issue blocked
//               sb_err_o                  - sticky underflow flag
// Config      : SB_WB_BYPASS_EN - when defined, a source whose single pending
//               write is being written back this cycle does not stall.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_scoreboard_ctrl
  import kl_pipe_pkg::*;
#(
  parameter  int NREGS = KL_NREGS,
  parameter  int CNT_W = KL_CNT_W,
  localparam int IDX_W = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid_i,
  input  logic [IDX_W-1:0] issue_rs_a_i,
  input  logic [IDX_W-1:0] issue_rs_b_i,
  input  logic             issue_use_a_i,
  input  logic             issue_use_b_i,
  input  logic             issue_write_i,
  input  logic [IDX_W-1:0] issue_rd_i,
  input  logic             wb_write_i,
  input  logic [IDX_W-1:0] wb_writenum_i,
  input  logic             drain_req_i,
  output logic             stall_o,
  output logic             issue_fire_o,
  output logic [NREGS-1:0] busy_mask_o,
  output logic             halted_o,
  output logic             sb_err_o
);

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [CNT_W-1:0] w_cnt [NREGS];
  logic [NREGS-1:0] w_inc;
  logic [NREGS-1:0] w_dec;
  logic [NREGS-1:0] w_sat;
  logic [NREGS-1:0] w_next_zero;
  logic [NREGS-1:0] w_uflow;

  sb_state_e state_q;
  sb_state_e state_d;
  logic      sb_err_q;

  // --------------------------------------------------------------------------
  // Per-register in-flight counters
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NREGS; i++) begin : g_cnt
      assign w_inc[i] = issue_fire_o && issue_write_i && (issue_rd_i == IDX_W'(i));
      assign w_dec[i] = wb_write_i && (wb_writenum_i == IDX_W'(i));

      sb_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .inc_i       (w_inc[i]),
        .dec_i       (w_dec[i]),
        .cnt_o       (w_cnt[i]),
        .sat_o       (w_sat[i]),
        .next_zero_o (w_next_zero[i]),
        .uflow_o     (w_uflow[i])
      );

      assign busy_mask_o[i] = |w_cnt[i];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] w_cnt_a;
  logic [CNT_W-1:0] w_cnt_b;
  logic             w_byp_a;
  logic             w_byp_b;
  logic             w_haz_a;
  logic             w_haz_b;
  logic             w_haz_sat;

  assign w_cnt_a = w_cnt[issue_rs_a_i];
  assign w_cnt_b = w_cnt[issue_rs_b_i];

`ifdef SB_WB_BYPASS_EN
  // The register file writes through, so the last outstanding write landing
  // this cycle is already visible to a read in the same cycle.
  assign w_byp_a = (w_cnt_a == C_ONE) && wb_write_i && (wb_writenum_i == issue_rs_a_i);
  assign w_byp_b = (w_cnt_b == C_ONE) && wb_write_i && (wb_writenum_i == issue_rs_b_i);
`else
  assign w_byp_a = 1'b0;
  assign w_byp_b = 1'b0;
`endif

  assign w_haz_a   = issue_use_a_i && (|w_cnt_a) && !w_byp_a;
  assign w_haz_b   = issue_use_b_i && (|w_cnt_b) && !w_byp_b;
  assign w_haz_sat = issue_write_i && w_sat[issue_rd_i];

  // --------------------------------------------------------------------------
  // Control FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (drain_req_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // A withdrawn request wins over completion in the same cycle.
        if (!drain_req_i)      state_d = ST_RUN;
        else if (&w_next_zero) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (!drain_req_i) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control FSM: outputs
  // --------------------------------------------------------------------------
  // A new drain request also blocks issue in the cycle it appears, so no new
  // work enters while the FSM moves to DRAIN.
  always_comb begin
    stall_o = 1'b0;
    if (issue_valid_i) begin
      if (state_q == ST_RUN) begin
        stall_o = drain_req_i || w_haz_a || w_haz_b || w_haz_sat;
      end else begin
        stall_o = 1'b1;
      end
    end
  end

  assign issue_fire_o = issue_valid_i && !stall_o;
  assign halted_o     = (state_q == ST_HALTED);

  // --------------------------------------------------------------------------
  // Sticky underflow flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_err_q <= 1'b0;
    end else if (|w_uflow) begin
      sb_err_q <= 1'b1;
    end
  end

  assign sb_err_o = sb_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_scoreboard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_scoreboard_ctrl
// Description : Self-checking bench for pipeline_scoreboard_ctrl. Directed
//               scenarios followed by randomized traffic; expected outputs
//               come from a counter-array reference model and are queued for
//               a separate monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_scoreboard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       issue_valid = 1'b0;
  logic [2:0] issue_rs_a = '0;
  logic [2:0] issue_rs_b = '0;
  logic       issue_use_a = 1'b0;
  logic       issue_use_b = 1'b0;
  logic       issue_write = 1'b0;
  logic [2:0] issue_rd = '0;
  logic       wb_write = 1'b0;
  logic [2:0] wb_writenum = '0;
  logic       drain_req = 1'b0;
  logic       stall;
  logic       issue_fire;
  logic [7:0] busy_mask;
  logic       halted;
  logic       sb_err;

  pipeline_scoreboard_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid_i (issue_valid),
    .issue_rs_a_i  (issue_rs_a),
    .issue_rs_b_i  (issue_rs_b),
    .issue_use_a_i (issue_use_a),
    .issue_use_b_i (issue_use_b),
    .issue_write_i (issue_write),
    .issue_rd_i    (issue_rd),
    .wb_write_i    (wb_write),
    .wb_writenum_i (wb_writenum),
    .drain_req_i   (drain_req),
    .stall_o       (stall),
    .issue_fire_o  (issue_fire),
    .busy_mask_o   (busy_mask),
    .halted_o      (halted),
    .sb_err_o      (sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    bit       stall;
    bit       fire;
    bit [7:0] busy;
    bit       halted;
    bit       err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model: plain per-register pending-write counts and a mode word
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;
  int m_cnt [8];
  int m_mode = M_RUN;
  bit m_err  = 1'b0;

  task automatic chk(input string name, input int c, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, c, got, want);
    end
  endtask

  // Monitor: one expected record per cycle, checked mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("stall",      e.cyc, int'(stall),      int'(e.stall));
        chk("issue_fire", e.cyc, int'(issue_fire), int'(e.fire));
        chk("busy_mask",  e.cyc, int'(busy_mask),  int'(e.busy));
        chk("halted",     e.cyc, int'(halted),     int'(e.halted));
        chk("sb_err",     e.cyc, int'(sb_err),     int'(e.err));
      end
    end
  end

  function automatic bit src_blocked(input int r, input bit wb, input int wn);
    bit byp;
    byp = 1'b0;
`ifdef SB_WB_BYPASS_EN
    byp = (m_cnt[r] == 1) && wb && (wn == r);
`endif
    return (m_cnt[r] > 0) && !byp;
  endfunction

  // Drive one cycle of inputs, queue the expected outputs, advance the model
  task automatic step(input bit v, input int a, input int b, input bit ua, input bit ub,
                      input bit w, input int rd, input bit wb, input int wn,
                      input bit dr, input bit r);
    exp_t e;
    bit   st;
    bit   all_zero;
    @(posedge clk);
    #1;
    cyc++;
    issue_valid = v;  issue_rs_a = 3'(a); issue_rs_b = 3'(b);
    issue_use_a = ua; issue_use_b = ub;   issue_write = w;
    issue_rd = 3'(rd); wb_write = wb;     wb_writenum = 3'(wn);
    drain_req = dr;   rst = r;

    st = v && ((m_mode != M_RUN) || dr || (ua && src_blocked(a, wb, wn)) ||
               (ub && src_blocked(b, wb, wn)) || (w && m_cnt[rd] == 3));
    e.cyc = cyc;
    e.stall = st;
    e.fire = v && !st;
    for (int i = 0; i < 8; i++) e.busy[i] = (m_cnt[i] != 0);
    e.halted = (m_mode == M_HALT);
    e.err = m_err;
    exp_q.push_back(e);

    if (r) begin
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      m_mode = M_RUN;
      m_err = 1'b0;
    end else begin
      if (wb && m_cnt[wn] == 0) m_err = 1'b1;
      if (e.fire && w && !(wb && wn == rd)) m_cnt[rd]++;
      if (wb && !(e.fire && w && wn == rd) && m_cnt[wn] > 0) m_cnt[wn]--;
      all_zero = 1'b1;
      for (int i = 0; i < 8; i++) if (m_cnt[i] != 0) all_zero = 1'b0;
      case (m_mode)
        M_RUN:   if (dr) m_mode = M_DRAIN;
        M_DRAIN: if (!dr) m_mode = M_RUN; else if (all_zero) m_mode = M_HALT;
        default: if (!dr) m_mode = M_RUN;
      endcase
    end
  endtask

  // Shorthands
  task automatic idle(input bit dr);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, dr, 0);
  endtask
  task automatic wr(input int rd, input bit wb, input int wn);
    step(1, 0, 0, 0, 0, 1, rd, wb, wn, 0, 0);
  endtask
  task automatic rd_a(input int a, input bit wb, input int wn);
    step(1, a, 0, 1, 0, 0, 0, wb, wn, 0, 0);
  endtask
  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;

    // Reset state, then read-after-write hazard on r3
    do_reset();
    idle(0);
    wr(3, 0, 0);
    rd_a(3, 0, 0);
    rd_a(3, 1, 3);
    rd_a(3, 0, 0);

    // Saturation on r5
    wr(5, 0, 0); wr(5, 0, 0); wr(5, 0, 0);
    wr(5, 0, 0);
    step(1, 0, 0, 0, 0, 1, 5, 1, 5, 0, 0);
    wr(5, 0, 0);
    for (int i = 0; i < 3; i++) idle(0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0);

    // Same-cycle write and writeback on r2 with one pending
    wr(2, 0, 0);
    wr(2, 1, 2);
    idle(0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);

    // Drain with r1 = 1, r4 = 2
    wr(1, 0, 0); wr(4, 0, 0); wr(4, 0, 0);
    step(1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 0);
    step(1, 0, 0, 0, 0, 1, 6, 1, 4, 1, 0);
    idle(1); idle(1);
    wr(6, 0, 0);
    wr(6, 0, 0);
    idle(0);

    // Underflow on r6 after its write retires, then reset clears it
    step(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0);
    idle(0); idle(0);
    do_reset();
    idle(0);

    // Reset in the middle of a drain with pending writes
    wr(0, 0, 0); wr(7, 0, 0);
    idle(1); idle(1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1); idle(0); idle(0);

    // Randomized traffic
    begin
      bit dr_l = 1'b0;
      for (int n = 0; n < 3000; n++) begin
        int wn;
        bit wb;
        wn = int'($urandom_range(0, 7));
        wb = (m_cnt[wn] > 0) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 63) == 0);
        if ($urandom_range(0, 39) == 0) dr_l = !dr_l;
        step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             int'($urandom_range(0, 7)), wb, wn, dr_l, ($urandom_range(0, 299) == 0));
      end
    end

    // Let the monitor consume the last record, then confirm nothing is left
    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", cyc, exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_scoreboard_ctrl.md
PIPELINE_SCOREBOARD_CTRL -- requirements
Module: pipeline_scoreboard_ctrl

Interface
REQ-001 Parameter NREGS, 8, number of architectural registers; register index width is log2(NREGS) = 3.
REQ-002 Parameter CNT_W, 2, width of each per-register in-flight counter; maximum count is 2^CNT_W-1 = 3.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 issue_valid  input  1  decode stage presents an instruction this cycle.
REQ-006 issue_rs_a / issue_rs_b  input  3 each  source register numbers.
REQ-007 issue_use_a / issue_use_b  input  1 each  the corresponding source is actually read.
REQ-008 issue_write / issue_rd  input  1 / 3  the instruction writes register issue_rd.
REQ-009 wb_write / wb_writenum  input  1 / 3  the writeback stage writes register wb_writenum this cycle.
REQ-010 drain_req  input  1  level request to quiesce the pipeline (debug halt, memory reconfiguration).
REQ-011 stall  output  1  combinational; decode must hold the instruction.
REQ-012 issue_fire  output  1  combinational; issue_valid & ~stall.
REQ-013 busy_mask  output  NREGS  registered; bit r = 1 when counter r is nonzero.
REQ-014 halted  output  1  registered; pipeline is drained and issue is blocked.
REQ-015 sb_err  output  1  registered, sticky; scoreboard underflow detected.

Function
REQ-016 Keep one CNT_W-bit counter per register, counting issued-but-not-written-back writes.
REQ-017 Increment: issue_fire & issue_write increments counter[issue_rd].
REQ-018 Decrement: wb_write decrements counter[wb_writenum].
REQ-019 Simultaneous increment and decrement of the same register leaves that counter unchanged.
REQ-020 Source hazard: a used source whose counter is nonzero raises stall.
REQ-021 Saturation guard: issue_write with counter[issue_rd] = 3 raises stall; counters never wrap.
REQ-022 Underflow: wb_write to a counter of 0 leaves the counter at 0 and sets sb_err until reset.
REQ-023 States: RUN, DRAIN, HALTED.
  - RUN -> DRAIN when drain_req = 1.
  - DRAIN -> HALTED when all counters are 0, including the effect of this cycle's decrement.
  - DRAIN -> RUN when drain_req drops before the drain completes.
  - HALTED -> RUN when drain_req = 0.
REQ-024 In DRAIN and HALTED, stall = 1 whenever issue_valid = 1; decrements continue.
REQ-025 halted = 1 exactly while the state is HALTED; it rises one cycle after the last counter reaches 0.
REQ-026 Latency: stall reflects current counters and inputs in the same cycle; counter and busy_mask updates are visible the next cycle.

Reset
REQ-027 rst clears all counters to 0, busy_mask to 0, halted to 0 and sb_err to 0, and sets the state to RUN.
REQ-028 rst has priority over all same-cycle issue, writeback and drain events.
REQ-029 Directly after reset, stall = 0 unless drain_req is asserted.

Configuration
REQ-030 Macro SB_WB_BYPASS_EN.
  - Defined: a used source whose counter is 1 and that equals wb_writenum while wb_write = 1 does not stall, because the register file forwards write-through.
  - Undefined: that case stalls for one extra cycle.
REQ-031 The saturation guard and drain behaviour are identical with and without the macro.

Structure
REQ-032 The shared package kl_pipe_pkg holds:
  - NREGS and CNT_W defaults;
  - the register-index typedef;
  - the state enum for RUN/DRAIN/HALTED;
  - opcode constants (including LDR = 3'b011).
REQ-033 One sub-module, sb_counter, implements a single saturating up/down counter with an underflow flag and is instantiated NREGS times.

Verification
REQ-034 Issue a write to r3 with no writeback; the next cycle issue a read of r3 -> stall = 1 and busy_mask = 8'h08; wb_write to r3 -> the read issues the following cycle (the same cycle with SB_WB_BYPASS_EN).
REQ-035 Issue three writes to r5 -> counter = 3; a fourth write to r5 -> stall = 1; one wb to r5 -> the fourth write issues.
REQ-036 Same cycle: issue write r2 and wb r2 with counter[r2] = 1 -> counter stays 1 and busy_mask[2] = 1.
REQ-037 With counters r1 = 1 and r4 = 2, assert drain_req -> stall = 1; after three wb cycles halted = 1; release drain_req -> halted = 0 and issue resumes.
REQ-038 wb_write to r6 with counter 0 -> sb_err = 1 and stays 1; rst -> sb_err = 0.
REQ-039 Assert rst mid-drain with nonzero counters -> the next cycle has all counters 0, state RUN, halted = 0.
